// File: rtl/volcado_banco.sv
// Register-file dump engine: walks an inclusive, wrapping address range, hands each
// word to a consumer through a valid/ready handshake and accumulates their sum.
module volcado_banco #(
  parameter int ANCHO_DATO = 32,
  parameter int ANCHO_DIR  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iniciar,
  input  logic [ANCHO_DIR-1:0]  dir_ini,
  input  logic [ANCHO_DIR-1:0]  dir_fin,
  input  logic                  abortar,
  output logic [ANCHO_DIR-1:0]  dirlec,
  input  logic [ANCHO_DATO-1:0] datolec,
  output logic [ANCHO_DATO-1:0] dato_sal,
  output logic [ANCHO_DIR-1:0]  dir_sal,
  output logic                  valido,
  input  logic                  listo,
  output logic                  ocupado,
  output logic                  hecho,
  output logic [ANCHO_DATO-1:0] suma
);

  typedef enum logic [1:0] {REPOSO, LEER, ENVIAR, FIN} estado_t;

  estado_t               estado, estado_sig;
  logic [ANCHO_DIR-1:0]  cont, dir_limite;
  logic                  transferencia, es_ultimo;

  assign dirlec        = cont;
  assign transferencia = valido && listo;
  assign es_ultimo     = (cont == dir_limite);

  always_ff @(posedge clk) begin
    if (rst) estado <= REPOSO;
    else     estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO: if (iniciar) estado_sig = LEER;
      LEER:   estado_sig = abortar ? REPOSO : ENVIAR;
      ENVIAR: begin
        if (abortar)            estado_sig = REPOSO;
        else if (transferencia) estado_sig = es_ultimo ? FIN : LEER;
      end
      FIN:     estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  always_comb begin
    valido  = (estado == ENVIAR);
    ocupado = (estado != REPOSO);
    hecho   = (estado == FIN);
  end

  // Data is sampled in LEER, so late register-file writes to unread words are seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      cont       <= '0;
      dir_limite <= '0;
      dato_sal   <= '0;
      dir_sal    <= '0;
      suma       <= '0;
    end else begin
      case (estado)
        REPOSO: begin
          if (iniciar) begin
            cont       <= dir_ini;
            dir_limite <= dir_fin;
            suma       <= '0;
          end
        end
        LEER: begin
          dato_sal <= datolec;
          dir_sal  <= cont;
          suma     <= suma + datolec;
        end
        ENVIAR: begin
          if (transferencia && !es_ultimo && !abortar) cont <= cont + ANCHO_DIR'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_volcado_banco.sv
// Directed bench for volcado_banco: a register-file model feeds datolec and a
// scoreboard queue of expected (address, word) pairs is drained on each handshake.
module tb_volcado_banco;

  typedef struct packed {
    logic [4:0]  dir;
    logic [31:0] dato;
  } esperado_t;

  logic        clk = 1'b0;
  logic        rst, iniciar, abortar, listo;
  logic [4:0]  dir_ini, dir_fin, dirlec, dir_sal;
  logic [31:0] datolec, dato_sal, suma;
  logic        valido, ocupado, hecho;

  logic [31:0] regs [0:31];
  esperado_t   sbq [$];
  int          errors = 0;
  int          checks = 0;

  assign datolec = regs[dirlec];

  always #5 clk = ~clk;

  volcado_banco #(.ANCHO_DATO(32), .ANCHO_DIR(5)) dut (
    .clk(clk), .rst(rst), .iniciar(iniciar), .dir_ini(dir_ini), .dir_fin(dir_fin),
    .abortar(abortar), .dirlec(dirlec), .datolec(datolec), .dato_sal(dato_sal),
    .dir_sal(dir_sal), .valido(valido), .listo(listo), .ocupado(ocupado),
    .hecho(hecho), .suma(suma)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Pulses iniciar for one edge and queues every word the dump should deliver.
  task automatic applyStimulus(input logic [4:0] ini, input logic [4:0] fin);
    logic [4:0] a;
    @(negedge clk);
    iniciar = 1'b1;
    dir_ini = ini;
    dir_fin = fin;
    a = ini;
    for (int k = 0; k < 32; k++) begin
      sbq.push_back('{dir: a, dato: regs[a]});
      if (a == fin) break;
      a = a + 5'd1;
    end
    @(negedge clk);
    iniciar = 1'b0;
    checkOutput("start_ocupado", {31'd0, ocupado}, 32'd1);
  endtask

  task automatic popCompare(input string tag);
    esperado_t e;
    if (sbq.size() == 0) begin
      checkOutput({tag, "_unexpected_word"}, 32'd1, {31'd0, valido & 1'b0});
    end else begin
      e = sbq.pop_front();
      checkOutput({tag, "_dir"}, {27'd0, dir_sal}, {27'd0, e.dir});
      checkOutput({tag, "_dato"}, dato_sal, e.dato);
    end
  endtask

  // Runs a started dump to completion, optionally stalling the first word and
  // injecting iniciar pulses, then checks sum, completion time and the single pulse.
  task automatic runDump(input string tag, input int stall, input logic [31:0] exp_suma,
                         input bit inject);
    int  cycles  = 0;
    int  stalled = 0;
    int  nwords  = sbq.size();
    bit  done    = 1'b0;
    listo = 1'b1;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      iniciar = inject && (cycles % 7 == 3);
      dir_ini = 5'd7;
      dir_fin = 5'd8;
      if (valido) begin
        if (stalled < stall) begin
          listo = 1'b0;
          stalled++;
          if (sbq.size() != 0) begin
            checkOutput({tag, "_stall_dir"}, {27'd0, dir_sal}, {27'd0, sbq[0].dir});
            checkOutput({tag, "_stall_dato"}, dato_sal, sbq[0].dato);
          end
        end else begin
          listo = 1'b1;
          popCompare(tag);
        end
      end
      if (hecho) begin
        checkOutput({tag, "_suma"}, suma, exp_suma);
        checkOutput({tag, "_cycles"}, cycles, 2 * nwords + stall);
        checkOutput({tag, "_left"}, sbq.size(), 0);
        done = 1'b1;
      end
    end
    iniciar = 1'b0;
    checkOutput({tag, "_completed"}, {31'd0, done}, 32'd1);
    @(negedge clk);
    checkOutput({tag, "_hecho_once"}, {31'd0, hecho}, 32'd0);
    checkOutput({tag, "_idle"}, {31'd0, ocupado}, 32'd0);
    checkOutput({tag, "_suma_held"}, suma, exp_suma);
    sbq.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valido"}, {31'd0, valido}, 32'd0);
    checkOutput({tag, "_hecho"}, {31'd0, hecho}, 32'd0);
    checkOutput({tag, "_ocupado"}, {31'd0, ocupado}, 32'd0);
    checkOutput({tag, "_dato_sal"}, dato_sal, 32'd0);
    checkOutput({tag, "_dir_sal"}, {27'd0, dir_sal}, 32'd0);
    checkOutput({tag, "_suma"}, suma, 32'd0);
    checkOutput({tag, "_dirlec"}, {27'd0, dirlec}, 32'd0);
  endtask

  initial begin
    int  seen;
    bit  reached;
    rst = 1'b1; iniciar = 1'b0; abortar = 1'b0; listo = 1'b1;
    dir_ini = '0; dir_fin = '0;
    for (int i = 0; i < 32; i++) regs[i] = i + 1;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;

    $display("[TB] basic dump 3..5");
    applyStimulus(5'd3, 5'd5);
    runDump("basic", 0, 32'd15, 1'b0);

    $display("[TB] wrapping dump 30..1");
    applyStimulus(5'd30, 5'd1);
    runDump("wrap", 0, 32'd66, 1'b0);

    $display("[TB] single word dump");
    applyStimulus(5'd9, 5'd9);
    runDump("single", 0, 32'd10, 1'b0);

    $display("[TB] stalled first word");
    applyStimulus(5'd3, 5'd5);
    runDump("stall", 5, 32'd15, 1'b0);

    $display("[TB] abort during second word");
    applyStimulus(5'd10, 5'd13);
    seen = 0; reached = 1'b0; listo = 1'b1;
    for (int c = 0; c < 40 && !reached; c++) begin
      @(negedge clk);
      if (valido) begin
        seen++;
        popCompare("abort");
        if (seen == 2) begin
          abortar = 1'b1;
          reached = 1'b1;
        end
      end
    end
    checkOutput("abort_reached", {31'd0, reached}, 32'd1);
    @(negedge clk);
    abortar = 1'b0;
    checkOutput("abort_ocupado", {31'd0, ocupado}, 32'd0);
    checkOutput("abort_valido", {31'd0, valido}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      checkOutput("abort_no_hecho", {31'd0, hecho}, 32'd0);
      @(negedge clk);
    end
    sbq.delete();
    applyStimulus(5'd2, 5'd3);
    runDump("restart", 0, 32'd7, 1'b0);

    $display("[TB] reset mid-handshake");
    applyStimulus(5'd0, 5'd5);
    reached = 1'b0;
    for (int c = 0; c < 10 && !reached; c++) begin
      @(negedge clk);
      if (valido) begin
        listo = 1'b0;
        reached = 1'b1;
      end
    end
    checkOutput("rst_reached", {31'd0, reached}, 32'd1);
    @(negedge clk);
    rst = 1'b1; iniciar = 1'b1; dir_ini = 5'd9; dir_fin = 5'd12;
    @(negedge clk);
    checkResetState("rst_mid");
    rst = 1'b0; iniciar = 1'b0; listo = 1'b1;
    @(negedge clk);
    checkOutput("rst_iniciar_ignored", {31'd0, ocupado}, 32'd0);
    sbq.delete();

    $display("[TB] full bank of all ones");
    for (int i = 0; i < 32; i++) regs[i] = 32'hFFFF_FFFF;
    applyStimulus(5'd0, 5'd31);
    runDump("full", 0, 32'hFFFF_FFE0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/volcado_banco.md
VOLCADO_BANCO -- requirements
Module: volcado_banco

Interface
REQ-001 Parameter: ANCHO_DATO, default 32, width of each register word.
REQ-002 Parameter: ANCHO_DIR, default 5, register address width (32 registers).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 iniciar  input  1  one-cycle start request; sampled only in REPOSO.
REQ-006 dir_ini  input  ANCHO_DIR  first register to dump; sampled with iniciar.
REQ-007 dir_fin  input  ANCHO_DIR  last register to dump, inclusive; sampled with iniciar.
REQ-008 abortar  input  1  cancels a dump in progress.
REQ-009 dirlec  output  ANCHO_DIR  register-file read address, driven to the register-file read port.
REQ-010 datolec  input  ANCHO_DATO  combinational read data returned by the register file for dirlec.
REQ-011 dato_sal  output  ANCHO_DATO  word presented to the consumer.
REQ-012 dir_sal  output  ANCHO_DIR  register address of dato_sal.
REQ-013 valido  output  1  dato_sal/dir_sal valid.
REQ-014 listo  input  1  consumer accepts the word; a transfer occurs when valido and listo are both 1.
REQ-015 ocupado  output  1  high in every state except REPOSO.
REQ-016 hecho  output  1  one-cycle pulse on completion of a full dump.
REQ-017 suma  output  ANCHO_DATO  modulo-2^ANCHO_DATO sum of the transferred words; valid while hecho is high and held until the next accepted iniciar.

Function
REQ-018 The FSM SHALL have states REPOSO, LEER, ENVIAR, FIN.
- REPOSO: iniciar=1 -> latch dir_ini into the address counter and dir_fin into the end register, clear suma, go to LEER. iniciar=0 -> stay.
- LEER: capture datolec into dato_sal and the counter into dir_sal, add datolec to suma, go to ENVIAR.
- ENVIAR: valido=1. valido&listo and counter==end -> FIN. valido&listo otherwise -> counter+1 modulo 32, go to LEER. No handshake -> stay with all outputs stable.
- FIN: hecho=1 for exactly one cycle, then REPOSO.
REQ-019 dirlec SHALL equal the address counter in every state.
REQ-020 The address counter SHALL wrap from 31 to 0, so that dir_fin < dir_ini dumps dir_ini..31 then 0..dir_fin.
- Word count = ((dir_fin - dir_ini) mod 32) + 1.
- dir_ini == dir_fin dumps exactly one word.
REQ-021 Minimum throughput SHALL be one word per 2 cycles; each ENVIAR cycle with listo=0 adds one cycle.
REQ-022 valido SHALL be 1 only in ENVIAR; dato_sal and dir_sal SHALL NOT change while valido=1 and listo=0.
REQ-023 iniciar while ocupado=1 SHALL be ignored, with no effect on the current dump.
REQ-024 abortar=1 in LEER or ENVIAR SHALL return to REPOSO on the next edge.
- No hecho pulse; valido deasserts that edge.
- A word handshaked in the same cycle as abortar counts as transferred; no further words follow.
REQ-025 abortar in REPOSO or FIN SHALL be ignored; FIN still pulses hecho.
REQ-026 suma SHALL count only words captured in LEER.
- Overflow wraps.
- After an abort, suma is undefined until the next hecho.
REQ-027 Register-file writes during a dump SHALL be visible to any register not yet read, because data is sampled in LEER.

Reset
REQ-028 rst=1 SHALL force REPOSO on the next edge from any state, including mid-handshake.
REQ-029 The reset values SHALL be:
- valido=0, hecho=0, ocupado=0
- dato_sal=0, dir_sal=0, suma=0
- dirlec=0 (address counter=0), end register=0.
REQ-030 rst SHALL take priority over iniciar and abortar in the same cycle.

Verification
REQ-031 Registers R[i]=i+1, iniciar with dir_ini=3, dir_fin=5, listo=1 -> words (3,4),(4,5),(5,6) on cycles 2,4,6 after iniciar; hecho one cycle later with suma=15.
REQ-032 dir_ini=30, dir_fin=1, same register contents -> dir_sal sequence 30,31,0,1; suma=31+32+1+2=66; hecho once.
REQ-033 listo held 0 for 5 cycles during the first ENVIAR -> valido, dato_sal, and dir_sal stable all 5 cycles; the dump completes with identical data.
REQ-034 abortar asserted during the 2nd ENVIAR of a 4-word dump -> ocupado=0 and valido=0 next cycle; hecho never pulses; a following iniciar restarts cleanly.
REQ-035 rst during ENVIAR with listo=0 -> next cycle all outputs hold their reset values; iniciar in the same cycle as rst is ignored.
REQ-036 All registers=0xFFFFFFFF, dir_ini=0, dir_fin=31 -> 32 transfers; suma=0xFFFFFFE0 (wrapped); iniciar pulses mid-dump ignored.
